// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// keypad_scanner : 4x4 matrix keypad scanner, one active-low column at a time,
//                  debounced press/release, hex key code with valid strobe.
// Revision       : 1.0
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Row_In,
    output logic [3:0] Col_Out,
    output logic [3:0] Key_Code,
    output logic       Key_Valid,
    output logic       Key_Down
);
    localparam int               DIV_W      = $clog2(SCAN_DIV);
    localparam int               CNT_W      = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ACCEPT = CNT_W'(DEBOUNCE - 1);

    localparam logic [1:0] S_SCAN     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_HELD     = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    logic [3:0]       sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             down_q, down_d;

    logic             tick;
    logic             row_open;
    logic [1:0]       low_row;
    logic [CNT_W-1:0] cnt_inc;

    assign tick     = (div_q == DIV_LAST);
    assign row_open = sync2_q[row_q];
    assign cnt_inc  = (cnt_q < CNT_MAX) ? cnt_q + CNT_ONE : cnt_q;

    // Lowest-numbered closed row wins when several rows are low together.
    always_comb begin
        low_row = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!sync2_q[i]) begin
                low_row = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
            div_q   <= '0;
            state_q <= S_SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            cnt_q   <= '0;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            sync1_q <= Row_In;
            sync2_q <= sync1_q;
            div_q   <= tick ? '0 : div_q + DIV_ONE;
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            down_q  <= down_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        down_d  = down_q;
        if (tick) begin
            case (state_q)
                S_SCAN: begin
                    if (sync2_q == 4'hF) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        row_d   = low_row;
                        cnt_d   = CNT_ONE;
                        state_d = S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (!row_open) begin
                        cnt_d = cnt_inc;
                        if (cnt_q >= CNT_ACCEPT) begin
                            code_d  = {row_q, col_q};
                            valid_d = 1'b1;
                            down_d  = 1'b1;
                            state_d = S_HELD;
                        end
                    end else begin
                        col_d   = col_q + 2'd1;
                        state_d = S_SCAN;
                    end
                end
                S_HELD: begin
                    if (row_open) begin
                        cnt_d   = CNT_ONE;
                        state_d = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // A re-close here is contact bounce: back to HELD, no new strobe.
                    if (row_open) begin
                        cnt_d = cnt_inc;
                        if (cnt_q >= CNT_ACCEPT) begin
                            down_d  = 1'b0;
                            col_d   = col_q + 2'd1;
                            state_d = S_SCAN;
                        end
                    end else begin
                        state_d = S_HELD;
                    end
                end
                default: state_d = S_SCAN;
            endcase
        end
    end

    always_comb begin
        Col_Out   = ~(4'b0001 << col_q);
        Key_Code  = code_q;
        Key_Valid = valid_q;
        Key_Down  = down_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_scanner : randomized keypad sessions against a physical keypad
//                     model, with a queue of expected key codes.
// Revision          : 1.0
// ============================================================================
module tb_keypad_scanner;
    localparam int SCAN_DIV = 8;
    localparam int DEBOUNCE = 4;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    logic [15:0] pressed;      // bit r*4+c closes the switch at row r, column c
    logic [3:0]  exp_q[$];
    int          n_vec;
    int          n_err;
    int          n_valid;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Row_In    (row_in),
        .Col_Out   (col_out),
        .Key_Code  (key_code),
        .Key_Valid (key_valid),
        .Key_Down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A row reads low when any closed switch on it sits on the driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d cycles required %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic set_key(input int r, input int c, input logic v);
        pressed[r*4+c] = v;
    endtask

    task automatic wait_valid(input string name, input int lo, input int hi);
        int start;
        int t;
        start = n_valid;
        t = 0;
        while (n_valid == start && t < 200) begin
            step();
            t++;
        end
        check_range(name, t, lo, hi);
    endtask

    task automatic wait_release(input string name, input int lo, input int hi);
        int t;
        t = 0;
        while (key_down && t < 200) begin
            step();
            t++;
        end
        check_range(name, t, lo, hi);
    endtask

    // Monitor: every strobe must match the oldest outstanding expected code.
    initial begin
        logic [3:0] want;
        forever begin
            @(negedge clk);
            if (rst && key_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid: got code %h required no pulse", key_code);
                end else begin
                    want = exp_q.pop_front();
                    check("key_code", key_code, want);
                    check("down_with_valid", key_down, 1);
                end
            end
        end
    end

    task automatic session(input int r, input int c, input bit bounce_press, input bit bounce_release);
        logic [3:0] code;
        logic [3:0] next_col;
        code = {2'(r), 2'(c)};
        next_col = ~(4'b0001 << ((c + 1) % 4));
        // Contacts of at most 16 cycles span at most 2 ticks and can never be accepted.
        if (bounce_press) begin
            repeat ($urandom_range(1, 3)) begin
                set_key(r, c, 1'b1);
                cycles($urandom_range(1, 16));
                set_key(r, c, 1'b0);
                cycles($urandom_range(20, 40));
            end
        end
        exp_q.push_back(code);
        set_key(r, c, 1'b1);
        wait_valid("press_latency", 25, 62);
        check("down_after_press", key_down, 1);
        cycles($urandom_range(10, 60));
        if (bounce_release) begin
            repeat ($urandom_range(1, 3)) begin
                set_key(r, c, 1'b0);
                cycles($urandom_range(1, 16));
                set_key(r, c, 1'b1);
                cycles($urandom_range(20, 40));
                check("down_through_bounce", key_down, 1);
            end
        end
        set_key(r, c, 1'b0);
        wait_release("release_latency", 25, 36);
        check("col_after_release", col_out, next_col);
        check("code_held", key_code, code);
        cycles($urandom_range(0, 20));
    endtask

    task automatic chord(input int c, input int r1, input int r2);
        exp_q.push_back({2'(r1), 2'(c)});
        exp_q.push_back({2'(r2), 2'(c)});
        set_key(r1, c, 1'b1);
        set_key(r2, c, 1'b1);
        wait_valid("chord_first_latency", 25, 62);
        cycles($urandom_range(10, 40));
        set_key(r1, c, 1'b0);
        wait_release("chord_release_latency", 25, 36);
        // Scan must go round the other three columns before re-detecting r2.
        wait_valid("chord_second_latency", 50, 62);
        cycles($urandom_range(10, 40));
        set_key(r2, c, 1'b0);
        wait_release("chord_final_release", 25, 36);
        cycles($urandom_range(0, 20));
    endtask

    task automatic reset_mid(input int r, input int c);
        logic [3:0] col_val;
        int t;
        col_val = ~(4'b0001 << c);
        set_key(r, c, 1'b1);
        t = 0;
        while (col_out != col_val && t < 60) begin
            step();
            t++;
        end
        check_range("reach_column", t, 0, 40);
        cycles(16);
        rst = 1'b0;
        #1;
        check("rst_col", col_out, 4'hE);
        check("rst_code", key_code, 0);
        check("rst_valid", key_valid, 0);
        check("rst_down", key_down, 0);
        cycles(3);
        rst = 1'b1;
        exp_q.push_back({2'(r), 2'(c)});
        wait_valid("redetect_latency", 25, 62);
        cycles($urandom_range(10, 30));
        set_key(r, c, 1'b0);
        wait_release("redetect_release", 25, 36);
        cycles($urandom_range(0, 20));
    endtask

    initial begin
        logic [3:0] prev;
        logic [3:0] want_col;
        int t;
        int r1;
        n_vec   = 0;
        n_err   = 0;
        n_valid = 0;
        pressed = '0;
        rst     = 1'b0;
        cycles(3);
        check("reset_col", col_out, 4'hE);
        check("reset_code", key_code, 0);
        check("reset_valid", key_valid, 0);
        check("reset_down", key_down, 0);
        rst = 1'b1;

        prev = col_out;
        for (int k = 1; k <= 5; k++) begin
            t = 0;
            while (col_out == prev && t < 20) begin
                step();
                t++;
            end
            want_col = ~(4'b0001 << (k % 4));
            check_range("col_step_interval", t, SCAN_DIV, SCAN_DIV);
            check("col_sequence", col_out, want_col);
            prev = col_out;
        end

        session(2, 1, 1'b0, 1'b0);
        session(0, 3, 1'b1, 1'b1);
        chord(0, 1, 3);
        reset_mid(2, 2);

        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 4))
                0: session($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
                1: session($urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'b0);
                2: session($urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b1);
                3: begin
                    r1 = $urandom_range(0, 2);
                    chord($urandom_range(0, 3), r1, $urandom_range(r1 + 1, 3));
                end
                default: reset_mid($urandom_range(0, 3), $urandom_range(0, 3));
            endcase
        end

        cycles(10);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
